// File: rtl/ecc_mm_sca_sequencer.sv
// rtl/ecc_mm_sca_sequencer.sv - Start/run/timeout sequencer around a modular multiplier for side-channel capture
module ecc_mm_sca_sequencer #(
    parameter int REG_SIZE = 384,
    parameter int TIMEOUT  = 4096
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                soft_reset_i,
    input  logic                start_req_i,
    input  logic [REG_SIZE-1:0] opa_i,
    input  logic [REG_SIZE-1:0] opb_i,
    output logic [REG_SIZE-1:0] mm_opa_o,
    output logic [REG_SIZE-1:0] mm_opb_o,
    output logic                mm_start_o,
    output logic                mm_reset_n_o,
    input  logic                mm_ready_i,
    input  logic [REG_SIZE-1:0] mm_p_i,
    output logic [REG_SIZE-1:0] result_o,
    output logic                result_val_o,
    output logic                trig_o,
    output logic                busy_o,
    output logic                timeout_o,
    output logic [2:0]          state_o
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t          state;
    logic            start_q;
    logic            armed_q;
    logic            mm_rst_q;
    logic [CW-1:0]   cnt;
    logic            request;

    // armed_q masks the first edge after reset so a start level already high is not taken as a request
    assign request      = start_req_i & ~start_q & armed_q;
    assign mm_reset_n_o = mm_rst_q & ~soft_reset_i;
    assign state_o      = state;

    // Sequencer state, counter and all registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            start_q      <= 1'b0;
            armed_q      <= 1'b0;
            mm_rst_q     <= 1'b0;
            cnt          <= '0;
            mm_opa_o     <= '0;
            mm_opb_o     <= '0;
            mm_start_o   <= 1'b0;
            result_o     <= '0;
            result_val_o <= 1'b0;
            trig_o       <= 1'b0;
            busy_o       <= 1'b0;
            timeout_o    <= 1'b0;
        end else begin
            start_q    <= start_req_i;
            armed_q    <= 1'b1;
            mm_rst_q   <= 1'b1;
            mm_start_o <= 1'b0;
            if (soft_reset_i) begin
                state        <= S_IDLE;
                cnt          <= '0;
                result_o     <= '0;
                result_val_o <= 1'b0;
                timeout_o    <= 1'b0;
                trig_o       <= 1'b0;
                busy_o       <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_DONE, S_ERR: begin
                        if (request) begin
                            state        <= S_LOAD;
                            mm_opa_o     <= opa_i;
                            mm_opb_o     <= opb_i;
                            result_val_o <= 1'b0;
                            timeout_o    <= 1'b0;
                            busy_o       <= 1'b1;
                        end
                    end
                    S_LOAD: begin
                        state      <= S_START;
                        mm_start_o <= 1'b1;
                        trig_o     <= 1'b1;
                        cnt        <= '0;
                    end
                    S_START: begin
                        state <= S_RUN;
                    end
                    S_RUN: begin
                        // cnt == 0 marks the first RUN cycle, where ready is not trusted
                        if (mm_ready_i && (cnt != '0)) begin
                            state        <= S_DONE;
                            result_o     <= mm_p_i;
                            result_val_o <= 1'b1;
                            trig_o       <= 1'b0;
                            busy_o       <= 1'b0;
                        end else if (cnt == CW'(TIMEOUT - 1)) begin
                            state     <= S_ERR;
                            timeout_o <= 1'b1;
                            mm_rst_q  <= 1'b0;
                            trig_o    <= 1'b0;
                            busy_o    <= 1'b0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: begin
                        state  <= S_IDLE;
                        trig_o <= 1'b0;
                        busy_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ecc_mm_sca_sequencer.sv
// tb/tb_ecc_mm_sca_sequencer.sv - Directed bench for the multiplier sequencer
module tb_ecc_mm_sca_sequencer;

    localparam int RS = 384;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          soft_reset;
    logic          start_req;
    logic [RS-1:0] opa, opb, p;
    logic          rdy, rdy16;

    logic [RS-1:0] a_opa, a_opb, a_res;
    logic          a_start, a_mrst, a_val, a_trig, a_busy, a_to;
    logic [2:0]    a_state;
    logic [RS-1:0] b_opa, b_opb, b_res;
    logic          b_start, b_mrst, b_val, b_trig, b_busy, b_to;
    logic [2:0]    b_state;

    int total = 0;
    int bad   = 0;
    int trig_cnt;
    int pulses;

    always #5 clk = ~clk;

    ecc_mm_sca_sequencer #(.REG_SIZE(RS), .TIMEOUT(128)) u_dut (
        .clk(clk), .reset_n(reset_n), .soft_reset_i(soft_reset), .start_req_i(start_req),
        .opa_i(opa), .opb_i(opb), .mm_opa_o(a_opa), .mm_opb_o(a_opb),
        .mm_start_o(a_start), .mm_reset_n_o(a_mrst), .mm_ready_i(rdy), .mm_p_i(p),
        .result_o(a_res), .result_val_o(a_val), .trig_o(a_trig), .busy_o(a_busy),
        .timeout_o(a_to), .state_o(a_state)
    );

    ecc_mm_sca_sequencer #(.REG_SIZE(RS), .TIMEOUT(16)) u_to (
        .clk(clk), .reset_n(reset_n), .soft_reset_i(soft_reset), .start_req_i(start_req),
        .opa_i(opa), .opb_i(opb), .mm_opa_o(b_opa), .mm_opb_o(b_opb),
        .mm_start_o(b_start), .mm_reset_n_o(b_mrst), .mm_ready_i(rdy16), .mm_p_i(p),
        .result_o(b_res), .result_val_o(b_val), .trig_o(b_trig), .busy_o(b_busy),
        .timeout_o(b_to), .state_o(b_state)
    );

    task automatic check(input string tag, input logic [RS-1:0] obs, input logic [RS-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0; soft_reset = 1'b0; start_req = 1'b1;
        opa = '0; opb = '0; p = '0; rdy = 1'b0; rdy16 = 1'b0;
        #2;
        check("rst_state", a_state, 0);
        check("rst_mm_reset_n", a_mrst, 0);
        check("rst_result", a_res, 0);
        check("rst_val_trig_busy_to", {a_val, a_trig, a_busy, a_to, a_start}, 0);
        check("rst_opa", a_opa, 0);

        @(negedge clk); reset_n = 1'b1;
        @(negedge clk);
        check("mm_reset_n_after_rst", a_mrst, 1);
        repeat (3) @(negedge clk);
        check("held_start_no_run", a_state, 0);
        start_req = 1'b0;
        @(negedge clk);

        // normal run: u_dut gets ready after 100 RUN cycles, u_to times out
        opa = 3; opb = 5; start_req = 1'b1;
        @(negedge clk);
        check("load_state", a_state, 1);
        check("load_no_start", a_start, 0);
        check("load_busy", a_busy, 1);
        @(negedge clk);
        check("start_latency", a_start, 1);
        check("opa_captured", a_opa, 3);
        check("opb_captured", a_opb, 5);
        trig_cnt = 0;
        for (int i = 0; i <= 100; i++) begin
            if (a_trig) trig_cnt++;
            if (i == 1) check("start_one_cycle", a_start, 0);
            if (i == 5) start_req = 1'b0;
            if (i == 6) start_req = 1'b1;
            if (i == 7) begin
                opa = 9;
                check("drop_req_in_run", a_state, 3);
            end
            if (i == 8) check("opa_stable", a_opa, 3);
            if (i == 16) check("to_still_run", b_state, 3);
            if (i == 17) begin
                check("to_err_state", b_state, 5);
                check("to_timeout", b_to, 1);
                check("to_mm_reset_low", b_mrst, 0);
                check("to_no_val", b_val, 0);
            end
            if (i == 18) begin
                check("to_mm_reset_back", b_mrst, 1);
                check("to_stays_err", b_state, 5);
            end
            if (i == 100) begin rdy = 1'b1; p = 384'hF; end
            @(negedge clk);
        end
        rdy = 1'b0;
        check("trig_cycles", trig_cnt, 101);
        check("done_state", a_state, 4);
        check("done_result", a_res, 384'hF);
        check("done_val", a_val, 1);
        check("done_trig_busy", {a_trig, a_busy, a_to}, 0);
        repeat (5) @(negedge clk);
        check("val_held", a_val, 1);
        check("done_no_queued_req", a_state, 4);

        // held start for 500 cycles yields one run
        start_req = 1'b0; p = 384'h1234;
        @(negedge clk);
        start_req = 1'b1;
        pulses = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (a_start) pulses++;
            if (i == 0) begin
                check("reload_clears_val", a_val, 0);
                check("reload_clears_to", b_to, 0);
            end
            if (i == 52) rdy = 1'b1;
            if (i == 53) rdy = 1'b0;
        end
        check("held_one_pulse", pulses, 1);
        check("held_done", a_state, 4);
        check("held_result", a_res, 384'h1234);

        // ready in first RUN cycle ignored; ready with timeout on u_to wins
        start_req = 1'b0;
        @(negedge clk);
        start_req = 1'b1;
        for (int i = 0; i <= 20; i++) begin
            @(negedge clk);
            if (i == 2) begin rdy = 1'b1; rdy16 = 1'b1; end
            if (i == 3) begin
                check("first_run_ready_ignored", a_state, 3);
                check("first_run_ready_ignored_to", b_state, 3);
                rdy = 1'b0; rdy16 = 1'b0;
            end
            if (i == 17) begin rdy16 = 1'b1; p = 384'hABC; end
            if (i == 18) begin
                check("ready_beats_timeout", b_state, 4);
                check("ready_beats_timeout_to", b_to, 0);
                check("ready_beats_timeout_res", b_res, 384'hABC);
                check("other_still_run", a_state, 3);
                rdy16 = 1'b0;
            end
        end

        // soft reset while running
        soft_reset = 1'b1;
        #1;
        check("soft_mm_reset_low", a_mrst, 0);
        @(negedge clk);
        check("soft_idle", a_state, 0);
        check("soft_clears_result", b_res, 0);
        check("soft_clears_flags", {a_val, a_trig, a_busy, b_val}, 0);
        soft_reset = 1'b0;
        @(negedge clk);
        check("soft_release_mm_reset", a_mrst, 1);

        // soft reset at RUN cycle 10, overriding a later request
        start_req = 1'b0;
        @(negedge clk);
        start_req = 1'b1;
        for (int i = 0; i <= 11; i++) @(negedge clk);
        check("run10_state", a_state, 3);
        soft_reset = 1'b1;
        @(negedge clk);
        check("soft_run10_idle", a_state, 0);
        check("soft_run10_no_val", a_val, 0);
        check("soft_run10_mm_reset", a_mrst, 0);
        start_req = 1'b0;
        @(negedge clk);
        start_req = 1'b1;
        @(negedge clk);
        check("soft_overrides_req", a_state, 0);
        soft_reset = 1'b0;
        @(negedge clk);
        check("no_run_after_soft", a_state, 0);

        // async reset mid-RUN
        start_req = 1'b0;
        @(negedge clk);
        start_req = 1'b1;
        repeat (6) @(negedge clk);
        check("pre_async_run", a_state, 3);
        #2 reset_n = 1'b0;
        #1;
        check("async_state", a_state, 0);
        check("async_flags", {a_start, a_mrst, a_val, a_trig, a_busy, a_to}, 0);
        check("async_opa", a_opa, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ecc_mm_sca_sequencer.md
ECC_MM_SCA_SEQUENCER -- requirements
Module: ecc_mm_sca_sequencer

Interface
REQ-001 SHALL have parameter REG_SIZE, default 384, meaning operand/result width.
REQ-002 SHALL have parameter TIMEOUT, default 4096, meaning max cycles waited for mm_ready_i.
REQ-003 SHALL have port clk  input  1  system clock; one clock, all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port soft_reset_i  input  1  host soft reset, synchronous, active-high.
REQ-006 SHALL have port start_req_i  input  1  host start level; its rising edge requests one run.
REQ-007 SHALL have ports opa_i, opb_i  input  REG_SIZE  host operands.
REQ-008 SHALL have ports mm_opa_o, mm_opb_o  output  REG_SIZE  registered operands to the multiplier.
REQ-009 SHALL have port mm_start_o  output  1  one-cycle multiplier start pulse.
REQ-010 SHALL have port mm_reset_n_o  output  1  multiplier reset, active-low.
REQ-011 SHALL have port mm_ready_i  input  1  multiplier done.
REQ-012 SHALL have port mm_p_i  input  REG_SIZE  multiplier result.
REQ-013 SHALL have port result_o  output  REG_SIZE  latched result.
REQ-014 SHALL have port result_val_o  output  1  result valid, level, held.
REQ-015 SHALL have port trig_o  output  1  scope trigger, high from start pulse through ready.
REQ-016 SHALL have ports busy_o, timeout_o  output  1  run in progress / last run timed out.
REQ-017 SHALL have port state_o  output  3  current state encoding for LED debug.

Function
REQ-018 States and encodings: IDLE=0, LOAD=1, START=2, RUN=3, DONE=4, ERR=5; other codes SHALL return to IDLE next cycle.
REQ-019 Start detect: registered copy of start_req_i; request = start_req_i & ~prev; a held-high level SHALL yield exactly one request.
REQ-020 IDLE/DONE/ERR + request -> LOAD; LOAD: capture opa_i/opb_i into mm_opa_o/mm_opb_o, clear result_val_o and timeout_o.
REQ-021 LOAD -> START (1 cycle, mm_start_o=1) -> RUN; mm_start_o SHALL be high in START only.
REQ-022 RUN: mm_ready_i ignored in first RUN cycle; thereafter mm_ready_i=1 -> DONE with result_o <= mm_p_i the same edge.
REQ-023 DONE: result_val_o=1 held until next LOAD or soft reset; result_o stable.
REQ-024 Cycle counter cleared in START, increments each RUN cycle; reaching TIMEOUT-1 without ready -> ERR, timeout_o=1.
REQ-025 Latency: request edge to mm_start_o = 2 cycles; mm_ready_i to result_val_o = 1 cycle.
REQ-026 ERR: mm_reset_n_o=0 for exactly the first ERR cycle, result_val_o=0; stays in ERR until request or soft reset.
REQ-027 mm_reset_n_o SHALL also be 0 while soft_reset_i=1, else 1.
REQ-028 busy_o=1 in LOAD, START, RUN; trig_o=1 in START and RUN, 0 elsewhere.
REQ-029 Request arriving in LOAD/START/RUN SHALL be dropped, not queued.
REQ-030 mm_ready_i and TIMEOUT reached same cycle: ready wins (DONE).
REQ-031 soft_reset_i=1 in any state -> IDLE next edge, clears result_o, result_val_o, timeout_o, counter; overrides a simultaneous request.
REQ-032 Operand outputs SHALL not change outside LOAD.

Reset
REQ-033 reset_n=0 SHALL asynchronously force: state IDLE, mm_start_o=0, mm_reset_n_o=0, result_o=0, result_val_o=0, trig_o=0, busy_o=0, timeout_o=0, state_o=0, operand registers 0, start-edge register 0.
REQ-034 After reset_n deasserts, mm_reset_n_o SHALL go 1 on the first clk edge; a start_req_i already high SHALL not trigger a run.

Verification
REQ-035 Normal run: opa=3, opb=5, start_req rises, model ready 100 cycles after start with p=0xF -> mm_start_o at cycle 2, trig high 101 cycles, result_o=0xF, result_val_o=1 held.
REQ-036 Held start: start_req_i high for 500 cycles, ready after 50 -> exactly one mm_start_o pulse, state DONE.
REQ-037 Timeout: TIMEOUT=16, ready never asserted -> ERR after 16 RUN cycles, timeout_o=1, one-cycle mm_reset_n_o low, result_val_o=0.
REQ-038 Soft reset mid-RUN: soft_reset_i at RUN cycle 10 -> IDLE next edge, mm_reset_n_o=0 while asserted, no result_val_o.
REQ-039 Ready and timeout same cycle, and ready in first RUN cycle -> DONE for former; latter ignored, run continues.
REQ-040 Async reset mid-RUN -> all outputs at REQ-033 values immediately, without clk edge.
